alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- Operand/issue stage directly upstream of the 8-bit combinational ALU.
- ALU opcodes: 0 OR, 1 NAND, 2 NOR, 3 AND, 4 ADD, 5 SUB; 6 and 7 yield 0.
- Accepts 8-bit instruction words over a valid/ready handshake and holds a six-entry register file, reg0..reg5.
- Drives the ALU's cmd/input1/input2 from registers and writes alu_result back, with blocking I/O ports and a conditional-branch output for the fetch stage.

Parameters:
UUID, 0, instance identifier; no functional effect
NAME, "", instance label; no functional effect

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
instr_valid  input  1  instruction word available
instr  input  8  instruction word
instr_ready  output  1  stage can accept an instruction this cycle
alu_cmd  output  8  ALU command; bits 7:3 always 0
alu_in1  output  8  ALU operand 1
alu_in2  output  8  ALU operand 2
alu_result  input  8  combinational ALU output
in_valid  input  1  external input data available
in_data  input  8  external input data
in_ready  output  1  stage consumes in_data this cycle
out_valid  output  1  out_data holds a value to emit
out_data  output  8  external output data
out_ready  input  1  consumer accepts out_data
branch_taken  output  1  one-cycle pulse: branch condition true
branch_target  output  8  reg0 value captured with branch_taken

Behaviour:
- Reset (rst low, asynchronous):
  - reg0..reg5 = 0; state = IDLE.
  - alu_cmd, alu_in1, alu_in2, out_data, branch_target = 0.
  - out_valid, in_ready, branch_taken = 0.
  - A pending output or input wait is dropped.
- FSM states: IDLE, EXEC, WAIT_IN, WAIT_OUT.
- Handshake: instr_ready = 1 only in IDLE. An instruction is accepted on a cycle with instr_valid & instr_ready. No instruction is accepted in any other state.
- Decode uses mode = instr[7:6].
  - 00 IMM: reg0 <= {2'b00, instr[5:0]}. Stays in IDLE, so throughput is 1 per cycle.
  - 01 CALC:
    - On accept, register alu_cmd <= {5'b0, instr[2:0]}, alu_in1 <= reg1, alu_in2 <= reg2; go to EXEC.
    - In EXEC: reg3 <= alu_result; return to IDLE. Latency is 2 cycles.
    - alu_cmd/alu_in1/alu_in2 hold their last values until the next CALC.
    - Operands are the reg1/reg2 values at accept time.
  - 10 COPY: src = instr[5:3], dst = instr[2:0].
    - src 0-5 reads regN; src 6 reads the external input port; src 7 reads 0.
    - dst 0-5 writes regN; dst 6 writes the external output port; dst 7 discards.
    - Register-to-register copy completes in the accept cycle. src == dst is a no-op.
    - src 6: go to WAIT_IN. in_ready = 1 there. On in_valid, latch in_data as the value, then:
      - dst 6: go to WAIT_OUT.
      - otherwise: write dst and return to IDLE.
    - dst 6: out_data <= value, out_valid <= 1, go to WAIT_OUT. Stay until out_valid & out_ready, then out_valid <= 0 and return to IDLE.
    - out_data stays stable while out_valid = 1.
  - 11 COND: test reg3 as signed 8-bit against cond = instr[2:0].
    - Codes: 0 never, 1 ==0, 2 <0, 3 <=0, 4 always, 5 !=0, 6 >=0, 7 >0.
    - If true: branch_taken = 1 for exactly the next cycle, with branch_target = reg0 as of accept.
    - Otherwise branch_taken stays 0. Stays in IDLE.
- Boundaries:
  - Back-to-back CALC: the second is accepted in the cycle after EXEC. Its reg1/reg2 read sees the prior writes.
  - COPY dst=3 immediately after CALC: sequential order is kept; the copy wins because EXEC precedes it.
  - Branch logic never reorders or stalls instructions; the fetch stage reacts to branch_taken.
  - Reset during WAIT_IN/WAIT_OUT returns to IDLE with no write or emit performed.

Test Plan:
- Reset, then instr 0x05 (IMM), 0x81 (COPY 0->1), 0x02 (IMM), 0x82 (COPY 0->2), 0x44 (CALC ADD) -> alu_in1=5, alu_in2=2, alu_cmd=4 in EXEC; reg3=7 afterwards; instr_ready low for exactly 1 cycle.
- reg1=0x03, reg2=0x05, instr 0x45 (SUB) -> reg3=0xFE. Then instr 0xC2 (COND <0) -> branch_taken one-cycle pulse; branch_target=reg0.
- reg3=0x00, instr 0xC7 (COND >0) -> no pulse. Then instr 0xC1 (==0) -> pulse.
- instr 0xB0 (COPY in->reg0), in_valid low for 3 cycles then high with in_data=0xA5 -> in_ready high throughout the wait; reg0=0xA5 after the handshake; instr_ready low until then.
- instr 0xB6 (COPY in->out), in_data=0x3C, out_ready low 4 cycles -> out_valid held with out_data=0x3C; clears the cycle after out_ready=1; IDLE afterwards.
- Drive rst low during WAIT_OUT -> out_valid=0 immediately; all registers 0; instr_ready=1 after release.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Operand/issue stage for the 8-bit ALU: decodes IMM/CALC/COPY/COND words,
// owns reg0..reg5, and performs blocking external I/O with valid/ready.
module alu_issue_stage #(
  parameter int UUID = 0,
  parameter     NAME = ""
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  output logic [7:0] alu_cmd,
  output logic [7:0] alu_in1,
  output logic [7:0] alu_in2,
  input  logic [7:0] alu_result,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       branch_taken,
  output logic [7:0] branch_target
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT_IN, WAIT_OUT} state_e;

  state_e     state_q, state_d;
  logic [7:0] regs_q [6];
  logic [7:0] regs_d [6];
  logic [7:0] alu_cmd_q, alu_cmd_d;
  logic [7:0] alu_in1_q, alu_in1_d;
  logic [7:0] alu_in2_q, alu_in2_d;
  logic [7:0] out_data_q, out_data_d;
  logic [2:0] dst_q, dst_d;
  logic       branch_taken_q, branch_taken_d;
  logic [7:0] branch_target_q, branch_target_d;

  logic [2:0] src, dst;
  logic [7:0] src_val;
  logic       r3_zero, r3_neg, cond_true;

  assign src = instr[5:3];
  assign dst = instr[2:0];

  always_comb begin
    src_val = '0;
    if (src < 3'd6) src_val = regs_q[src];
  end

  always_comb begin
    r3_zero = (regs_q[3] == 8'h00);
    r3_neg  = regs_q[3][7];
    unique case (instr[2:0])
      3'd0:    cond_true = 1'b0;
      3'd1:    cond_true = r3_zero;
      3'd2:    cond_true = r3_neg;
      3'd3:    cond_true = r3_neg | r3_zero;
      3'd4:    cond_true = 1'b1;
      3'd5:    cond_true = ~r3_zero;
      3'd6:    cond_true = ~r3_neg;
      default: cond_true = ~r3_neg & ~r3_zero;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    regs_d          = regs_q;
    alu_cmd_d       = alu_cmd_q;
    alu_in1_d       = alu_in1_q;
    alu_in2_d       = alu_in2_q;
    out_data_d      = out_data_q;
    dst_d           = dst_q;
    branch_taken_d  = 1'b0;
    branch_target_d = branch_target_q;
    unique case (state_q)
      IDLE: if (instr_valid) begin
        unique case (instr[7:6])
          2'b00: regs_d[0] = {2'b00, instr[5:0]};
          2'b01: begin
            alu_cmd_d = {5'b0, instr[2:0]};
            alu_in1_d = regs_q[1];
            alu_in2_d = regs_q[2];
            state_d   = EXEC;
          end
          2'b10: begin
            // External input defers everything, including the output leg.
            if (src == 3'd6) begin
              dst_d   = dst;
              state_d = WAIT_IN;
            end else if (dst == 3'd6) begin
              out_data_d = src_val;
              state_d    = WAIT_OUT;
            end else if (dst < 3'd6) begin
              regs_d[dst] = src_val;
            end
          end
          default: begin
            branch_taken_d = cond_true;
            if (cond_true) branch_target_d = regs_q[0];
          end
        endcase
      end
      EXEC: begin
        regs_d[3] = alu_result;
        state_d   = IDLE;
      end
      WAIT_IN: if (in_valid) begin
        if (dst_q == 3'd6) begin
          out_data_d = in_data;
          state_d    = WAIT_OUT;
        end else begin
          if (dst_q < 3'd6) regs_d[dst_q] = in_data;
          state_d = IDLE;
        end
      end
      default: if (out_ready) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      for (int unsigned i = 0; i < 6; i++) regs_q[i] <= '0;
      alu_cmd_q       <= '0;
      alu_in1_q       <= '0;
      alu_in2_q       <= '0;
      out_data_q      <= '0;
      dst_q           <= '0;
      branch_taken_q  <= 1'b0;
      branch_target_q <= '0;
    end else begin
      state_q         <= state_d;
      regs_q          <= regs_d;
      alu_cmd_q       <= alu_cmd_d;
      alu_in1_q       <= alu_in1_d;
      alu_in2_q       <= alu_in2_d;
      out_data_q      <= out_data_d;
      dst_q           <= dst_d;
      branch_taken_q  <= branch_taken_d;
      branch_target_q <= branch_target_d;
    end
  end

  assign instr_ready   = (state_q == IDLE);
  assign in_ready      = (state_q == WAIT_IN);
  assign out_valid     = (state_q == WAIT_OUT);
  assign out_data      = out_data_q;
  assign alu_cmd       = alu_cmd_q;
  assign alu_in1       = alu_in1_q;
  assign alu_in2       = alu_in2_q;
  assign branch_taken  = branch_taken_q;
  assign branch_target = branch_target_q;

endmodule
